// File: rtl/alu_pkg.sv
// Package: alu_pkg
// Shared constants for the 8-bit ALU datapath and its board-side operand
// loader: datapath widths, button roles, load-flag bit positions, ALU
// opcodes and the loader FSM state type.
package alu_pkg;

  localparam int ALU_W = 8;
  localparam int SEL_W = 4;

  // Button roles (index into BTN[3:0])
  localparam int BTN_LOAD_A  = 0;
  localparam int BTN_LOAD_B  = 1;
  localparam int BTN_LOAD_OP = 2;
  localparam int BTN_EXEC    = 3;

  // Bit positions inside load_flags
  localparam int FLAG_A  = 0;
  localparam int FLAG_B  = 1;
  localparam int FLAG_OP = 2;

  // Opcodes understood by the ALU
  localparam logic [SEL_W-1:0] OP_ADD  = 4'h0;
  localparam logic [SEL_W-1:0] OP_SUB  = 4'h1;
  localparam logic [SEL_W-1:0] OP_MUL  = 4'h2;
  localparam logic [SEL_W-1:0] OP_DIV  = 4'h3;
  localparam logic [SEL_W-1:0] OP_SHL  = 4'h4;
  localparam logic [SEL_W-1:0] OP_SHR  = 4'h5;
  localparam logic [SEL_W-1:0] OP_ROL  = 4'h6;
  localparam logic [SEL_W-1:0] OP_ROR  = 4'h7;
  localparam logic [SEL_W-1:0] OP_AND  = 4'h8;
  localparam logic [SEL_W-1:0] OP_OR   = 4'h9;
  localparam logic [SEL_W-1:0] OP_XOR  = 4'hA;
  localparam logic [SEL_W-1:0] OP_NOR  = 4'hB;
  localparam logic [SEL_W-1:0] OP_NAND = 4'hC;
  localparam logic [SEL_W-1:0] OP_XNOR = 4'hD;
  localparam logic [SEL_W-1:0] OP_GT   = 4'hE;
  localparam logic [SEL_W-1:0] OP_EQ   = 4'hF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } ldr_state_e;

  // An operation may only be issued once A, B and the opcode were all loaded.
  function automatic logic all_loaded(input logic [2:0] flags);
    return &flags;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Module: btn_debounce
// One push button: 2-FF synchroniser, stability counter and rising-edge
// detector. The debounced level only follows the synchronised input after it
// has differed from it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk     in  1  system clock
//   rst_n   in  1  synchronous reset, active-low
//   btn_raw in  1  raw asynchronous button (active-high, bouncing)
//   press   out 1  registered one-cycle pulse per accepted press
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             press_q, press_d;

  // Stability counter: runs only while the synced input disagrees with the
  // accepted level, and restarts the moment they agree again.
  always_comb begin
    cnt_d   = {CNT_W{1'b0}};
    level_d = level_q;
    press_d = level_q & ~level_dly_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Synchroniser, debounce state and registered press pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Module: alu_operand_loader
// Board-side front end for the 8-bit ALU. Debounces BTN[3:0], captures
// operands A, B and the opcode from the synchronised switches, and issues the
// {A,B,ALU_Sel} triple over a valid/ready handshake.
// Ports:
//   clk        in  1  system clock
//   rst_n      in  1  synchronous reset, active-low
//   SW         in  8  raw slide switches
//   BTN        in  4  raw push buttons (0:load A, 1:load B, 2:load op, 3:execute)
//   A, B       out 8  operands to the ALU
//   ALU_Sel    out 4  opcode to the ALU
//   op_valid   out 1  triple valid for consumption
//   op_ready   in  1  ALU accepts on op_valid & op_ready
//   load_flags out 3  {op_loaded,b_loaded,a_loaded}
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ALU_W-1:0] SW,
  input  logic [3:0]       BTN,
  output logic [ALU_W-1:0] A,
  output logic [ALU_W-1:0] B,
  output logic [SEL_W-1:0] ALU_Sel,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [2:0]       load_flags
);

  logic [3:0]       press;
  logic [ALU_W-1:0] sw_meta_q, sw_sync_q;

  ldr_state_e       state_q, state_d;
  // Capture registers always hold the most recently loaded values.
  logic [ALU_W-1:0] a_q, a_d, b_q, b_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [2:0]       flags_q, flags_d;
  // Presented registers drive the ALU; they freeze while an issue is pending.
  logic [ALU_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             valid_q, valid_d;

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(BTN[gi]),
      .press  (press[gi])
    );
  end

  // Capture and issue control for the two-state FSM.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    flags_d   = flags_q;
    out_a_d   = out_a_q;
    out_b_d   = out_b_q;
    out_sel_d = out_sel_q;
    valid_d   = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (press[BTN_LOAD_A]) begin
          a_d             = sw_sync_q;
          flags_d[FLAG_A] = 1'b1;
        end else begin
          a_d = a_q;
        end
        if (press[BTN_LOAD_B]) begin
          b_d             = sw_sync_q;
          flags_d[FLAG_B] = 1'b1;
        end else begin
          b_d = b_q;
        end
        if (press[BTN_LOAD_OP]) begin
          sel_d            = sw_sync_q[SEL_W-1:0];
          flags_d[FLAG_OP] = 1'b1;
        end else begin
          sel_d = sel_q;
        end
        // A simultaneous execute sees the values and flags from before this
        // cycle's loads, so issue from the capture registers' current state.
        if (press[BTN_EXEC] && all_loaded(flags_q)) begin
          state_d   = ST_ISSUE;
          valid_d   = 1'b1;
          out_a_d   = a_q;
          out_b_d   = b_q;
          out_sel_d = sel_q;
        end else begin
          out_a_d   = a_d;
          out_b_d   = b_d;
          out_sel_d = sel_d;
        end
      end
      ST_ISSUE: begin
        // Handshake done: re-expose the capture registers, which may have
        // been loaded in the same cycle that execute was pressed.
        if (op_ready) begin
          state_d   = ST_IDLE;
          valid_d   = 1'b0;
          out_a_d   = a_q;
          out_b_d   = b_q;
          out_sel_d = sel_q;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Switch synchroniser, capture registers and FSM state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta_q <= {ALU_W{1'b0}};
      sw_sync_q <= {ALU_W{1'b0}};
      state_q   <= ST_IDLE;
      a_q       <= {ALU_W{1'b0}};
      b_q       <= {ALU_W{1'b0}};
      sel_q     <= {SEL_W{1'b0}};
      flags_q   <= 3'b000;
      out_a_q   <= {ALU_W{1'b0}};
      out_b_q   <= {ALU_W{1'b0}};
      out_sel_q <= {SEL_W{1'b0}};
      valid_q   <= 1'b0;
    end else begin
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      flags_q   <= flags_d;
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
      out_sel_q <= out_sel_d;
      valid_q   <= valid_d;
    end
  end

  assign A          = out_a_q;
  assign B          = out_b_q;
  assign ALU_Sel    = out_sel_q;
  assign op_valid   = valid_q;
  assign load_flags = flags_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader with DEBOUNCE_CYCLES=4. A reference model
// tracks operands/flags at press granularity; issued operations are queued
// and a monitor compares every presented triple and handshake.
module tb_alu_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] SW;
  logic [3:0] BTN;
  logic [7:0] A, B;
  logic [3:0] ALU_Sel;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] load_flags;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;

  // Reference model state
  logic [7:0]  m_a, m_b;
  logic [3:0]  m_sel;
  logic [2:0]  m_flags;
  logic [19:0] sb_q[$];

  alu_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .SW(SW), .BTN(BTN), .A(A), .B(B),
    .ALU_Sel(ALU_Sel), .op_valid(op_valid), .op_ready(op_ready),
    .load_flags(load_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every presented triple must equal the oldest expected issue.
  always @(negedge clk) begin
    if (rst_n && op_valid) begin
      valid_cycles++;
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        chk("issued_triple", {12'd0, A, B, ALU_Sel}, {12'd0, sb_q[0]});
        if (op_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_a = 8'h00; m_b = 8'h00; m_sel = 4'h0; m_flags = 3'b000;
    sb_q.delete();
  endtask

  task automatic do_reset();
    BTN = 4'h0; op_ready = 1'b0; rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    model_reset();
    step(1);
  endtask

  task automatic check_state(input string nm);
    chk({nm, "_A"}, {24'd0, A}, {24'd0, m_a});
    chk({nm, "_B"}, {24'd0, B}, {24'd0, m_b});
    chk({nm, "_sel"}, {28'd0, ALU_Sel}, {28'd0, m_sel});
    chk({nm, "_flags"}, {29'd0, load_flags}, {29'd0, m_flags});
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!op_valid && n < 20) begin
      step(1);
      n++;
    end
    chk({nm, "_valid_rise"}, {31'd0, op_valid}, 32'd1);
  endtask

  // One press of the buttons in mask with switches sw; an issued operation is
  // accepted ready_delay cycles after op_valid rises.
  task automatic do_action(input string nm, input logic [3:0] mask, input logic [7:0] sw,
                           input int ready_delay, input logic idle_ready);
    logic issue;
    logic saw_valid;
    issue = mask[3] && (m_flags == 3'b111);
    if (issue) sb_q.push_back({m_a, m_b, m_sel});
    if (mask[0]) begin m_a = sw; m_flags[0] = 1'b1; end
    if (mask[1]) begin m_b = sw; m_flags[1] = 1'b1; end
    if (mask[2]) begin m_sel = sw[3:0]; m_flags[2] = 1'b1; end
    SW = sw;
    op_ready = issue ? 1'b0 : idle_ready;
    BTN = mask;
    if (issue) begin
      wait_valid(nm);
      step(ready_delay);
      op_ready = 1'b1;
      step(1);
      op_ready = 1'b0;
      chk({nm, "_valid_drop"}, {31'd0, op_valid}, 32'd0);
      BTN = 4'h0;
      step(14);
    end else begin
      saw_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
        step(1);
        if (op_valid) saw_valid = 1'b1;
      end
      if (mask[3]) chk({nm, "_no_issue"}, {31'd0, saw_valid}, 32'd0);
      BTN = 4'h0;
      step(14);
    end
    op_ready = 1'b0;
    check_state(nm);
  endtask

  initial begin
    logic bounce_bad;
    logic [3:0] rmask;
    rst_n = 1'b0; SW = 8'h00; BTN = 4'h0; op_ready = 1'b0;
    model_reset();
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("reset_valid", {31'd0, op_valid}, 32'd0);
    check_state("reset");

    // 1: bouncing BTN0 then a stable hold -> exactly one capture
    SW = 8'hA5;
    bounce_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      BTN = ((i / 2) % 2 == 0) ? 4'h1 : 4'h0;
      step(1);
      if (load_flags != 3'b000 || A != 8'h00) bounce_bad = 1'b1;
    end
    chk("bounce_no_capture", {31'd0, bounce_bad}, 32'd0);
    BTN = 4'h1;
    step(10);
    m_a = 8'hA5; m_flags = 3'b001;
    check_state("bounce_capture");
    SW = 8'h11;
    step(10);
    chk("hold_single_capture", {24'd0, A}, 32'hA5);
    BTN = 4'h0;
    step(12);
    chk("release_no_capture", {24'd0, A}, 32'hA5);

    // 2: full load, execute with 5 stall cycles
    do_action("load_a", 4'h1, 8'hF0, 0, 1'b0);
    do_action("load_b", 4'h2, 8'h0F, 0, 1'b1);
    do_action("load_op", 4'h4, 8'h03, 0, 1'b0);
    valid_cycles = 0;
    do_action("exec_stall", 4'h8, 8'h00, 5, 1'b0);
    chk("exec_valid_cycles", valid_cycles, 32'd6);

    // 4: load press during ISSUE is dropped
    sb_q.push_back({m_a, m_b, m_sel});
    op_ready = 1'b0; BTN = 4'h8;
    wait_valid("issue_drop");
    BTN = 4'h1; SW = 8'h55;
    step(16);
    chk("issue_A_frozen", {24'd0, A}, 32'hF0);
    BTN = 4'h0;
    step(2);
    op_ready = 1'b1;
    step(1);
    op_ready = 1'b0;
    chk("issue_drop_valid_low", {31'd0, op_valid}, 32'd0);
    step(14);
    check_state("issue_drop_after");

    // 3: execute with only A loaded is ignored
    do_reset();
    do_action("partial_a", 4'h1, 8'h77, 0, 1'b1);
    do_action("partial_exec", 4'h8, 8'h00, 0, 1'b1);

    // 5: simultaneous BTN0 and BTN1
    do_reset();
    do_action("dual_load", 4'h3, 8'h3C, 0, 1'b0);

    // Randomized presses, including execute concurrent with loads
    for (int it = 0; it < 40; it++) begin
      rmask = 4'($urandom_range(1, 15));
      do_action("rand", rmask, 8'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
    end
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    // 6: reset while op_valid is high
    do_action("r_load", 4'h7, 8'h9A, 0, 1'b0);
    sb_q.push_back({m_a, m_b, m_sel});
    op_ready = 1'b0; BTN = 4'h8;
    wait_valid("rst_issue");
    BTN = 4'h0;
    step(2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    model_reset();
    chk("rst_valid", {31'd0, op_valid}, 32'd0);
    check_state("rst_mid");
    op_ready = 1'b1;
    step(12);
    op_ready = 1'b0;
    chk("rst_stays_idle", {31'd0, op_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
